tdc_fifo_write_arbiter: RTL and testbench



---
 rtl/tdc_pkg.sv | 24 ++
 rtl/tdc_src_slot.sv | 47 ++++
 rtl/tdc_fifo_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_tdc_fifo_write_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// rtl/tdc_pkg.sv - shared tags, marker codes and source indices for the TDC FIFO write path
package tdc_pkg;

    localparam logic [15:0] TAG_S1     = 16'h0001;
    localparam logic [15:0] TAG_S2     = 16'h0002;
    localparam logic [15:0] TAG_MARK   = 16'h0001;
    localparam logic [15:0] LINE_CODE  = 16'h000D;
    localparam logic [15:0] FRAME_CODE = 16'h000E;

    localparam int DATA_W = 48;
    localparam int AGE_W  = 8;

    typedef enum logic [1:0] {
        SRC_S1,
        SRC_S2,
        SRC_LINE,
        SRC_FRAME
    } src_e;

    function automatic logic [63:0] marker_word(input logic [15:0] code);
        return {TAG_MARK, code, code, code};
    endfunction

endpackage

// File: rtl/tdc_src_slot.sv
// rtl/tdc_src_slot.sv - one-entry holding slot with pending bit, optional payload and drop detect
module tdc_src_slot #(
    parameter int PAYLOAD_W = 48,
    localparam int DW = (PAYLOAD_W > 0) ? PAYLOAD_W : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [DW-1:0] din,
    input  logic          grant,
    output logic          pending,
    output logic [DW-1:0] payload,
    output logic          drop
);

    logic          pending_q, pending_d;
    logic [DW-1:0] payload_q, payload_d;

    always_comb begin
        pending_d = pending_q;
        payload_d = payload_q;
        // A grant frees the slot this cycle, so a coincident request refills it instead of dropping.
        if (grant) begin
            pending_d = req;
        end else if (req && !pending_q) begin
            pending_d = 1'b1;
        end
        if (req && (!pending_q || grant)) begin
            payload_d = din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            payload_q <= '0;
        end else begin
            pending_q <= pending_d;
            payload_q <= payload_d;
        end
    end

    assign pending = pending_q;
    assign payload = payload_q;
    assign drop    = req && pending_q && !grant;

endmodule

// File: rtl/tdc_fifo_write_arbiter.sv
// rtl/tdc_fifo_write_arbiter.sv - serializes s1/s2 data and line/frame markers onto the TDC FIFO write port
module tdc_fifo_write_arbiter
    import tdc_pkg::*;
#(
    parameter int MARKER_MAX_WAIT = 16,
    parameter int DROP_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s1_req,
    input  logic [DATA_W-1:0]     s1_din,
    input  logic                  s2_req,
    input  logic [DATA_W-1:0]     s2_din,
    input  logic                  line_req,
    input  logic                  frame_req,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [63:0]           fifo_din,
    output logic                  s1_done,
    output logic                  s2_done,
    output logic                  line_done,
    output logic                  frame_done,
    output logic [DROP_CNT_W-1:0] drop_count,
    output logic                  overflow
);

    logic              s1_pend, s2_pend, line_pend, frame_pend;
    logic              s1_drop, s2_drop, line_drop, frame_drop;
    logic              s1_grant, s2_grant, line_grant, frame_grant;
    logic [DATA_W-1:0] s1_payload, s2_payload;
    logic              line_payload_unused, frame_payload_unused;

    tdc_src_slot #(.PAYLOAD_W(DATA_W)) u_s1_slot (
        .clk(clk), .rst_n(rst_n), .req(s1_req), .din(s1_din), .grant(s1_grant),
        .pending(s1_pend), .payload(s1_payload), .drop(s1_drop)
    );
    tdc_src_slot #(.PAYLOAD_W(DATA_W)) u_s2_slot (
        .clk(clk), .rst_n(rst_n), .req(s2_req), .din(s2_din), .grant(s2_grant),
        .pending(s2_pend), .payload(s2_payload), .drop(s2_drop)
    );
    tdc_src_slot #(.PAYLOAD_W(0)) u_line_slot (
        .clk(clk), .rst_n(rst_n), .req(line_req), .din(1'b0), .grant(line_grant),
        .pending(line_pend), .payload(line_payload_unused), .drop(line_drop)
    );
    tdc_src_slot #(.PAYLOAD_W(0)) u_frame_slot (
        .clk(clk), .rst_n(rst_n), .req(frame_req), .din(1'b0), .grant(frame_grant),
        .pending(frame_pend), .payload(frame_payload_unused), .drop(frame_drop)
    );

    logic                  fifo_wr_en_q, fifo_wr_en_d;
    logic [63:0]           fifo_din_q, fifo_din_d;
    logic [3:0]            done_q, done_d;
    logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;
    logic                  overflow_q, overflow_d;
    logic                  last_s1_q, last_s1_d;
    logic [AGE_W-1:0]      line_age_q, line_age_d;
    logic [AGE_W-1:0]      frame_age_q, frame_age_d;

    logic                  grant_valid;
    src_e                  grant_src;
    logic                  line_aged, frame_aged;
    logic [2:0]            drop_sum;
    logic [DROP_CNT_W:0]   drop_ext;

    assign line_aged  = line_age_q  >= AGE_W'(MARKER_MAX_WAIT);
    assign frame_aged = frame_age_q >= AGE_W'(MARKER_MAX_WAIT);

    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_S1;
        if (!fifo_full) begin
            grant_valid = 1'b1;
            if (line_pend && line_aged) begin
                grant_src = SRC_LINE;
            end else if (frame_pend && frame_aged) begin
                grant_src = SRC_FRAME;
            end else if (s1_pend && s2_pend) begin
                grant_src = last_s1_q ? SRC_S2 : SRC_S1;
            end else if (s1_pend) begin
                grant_src = SRC_S1;
            end else if (s2_pend) begin
                grant_src = SRC_S2;
            end else if (line_pend) begin
                grant_src = SRC_LINE;
            end else if (frame_pend) begin
                grant_src = SRC_FRAME;
            end else begin
                grant_valid = 1'b0;
            end
        end
    end

    assign s1_grant    = grant_valid && (grant_src == SRC_S1);
    assign s2_grant    = grant_valid && (grant_src == SRC_S2);
    assign line_grant  = grant_valid && (grant_src == SRC_LINE);
    assign frame_grant = grant_valid && (grant_src == SRC_FRAME);

    always_comb begin
        fifo_wr_en_d = grant_valid;
        fifo_din_d   = fifo_din_q;
        done_d       = {frame_grant, line_grant, s2_grant, s1_grant};
        last_s1_d    = last_s1_q;
        if (grant_valid) begin
            case (grant_src)
                SRC_S1:    fifo_din_d = {TAG_S1, s1_payload};
                SRC_S2:    fifo_din_d = {TAG_S2, s2_payload};
                SRC_LINE:  fifo_din_d = marker_word(LINE_CODE);
                default:   fifo_din_d = marker_word(FRAME_CODE);
            endcase
        end
        if (s1_grant) last_s1_d = 1'b1;
        if (s2_grant) last_s1_d = 1'b0;

        // grant_valid already implies fifo_full is low, so ages freeze while full.
        line_age_d = line_age_q;
        if (!line_pend || line_grant) begin
            line_age_d = '0;
        end else if (grant_valid && line_age_q != '1) begin
            line_age_d = line_age_q + 1'b1;
        end
        frame_age_d = frame_age_q;
        if (!frame_pend || frame_grant) begin
            frame_age_d = '0;
        end else if (grant_valid && frame_age_q != '1) begin
            frame_age_d = frame_age_q + 1'b1;
        end

        drop_sum = {2'b0, s1_drop} + {2'b0, s2_drop} + {2'b0, line_drop} + {2'b0, frame_drop};
        drop_ext = {1'b0, drop_count_q} + {{(DROP_CNT_W-2){1'b0}}, drop_sum};
        drop_count_d = drop_ext[DROP_CNT_W] ? '1 : drop_ext[DROP_CNT_W-1:0];
        overflow_d   = overflow_q || (drop_sum != 3'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_wr_en_q <= 1'b0;
            fifo_din_q   <= '0;
            done_q       <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
            last_s1_q    <= 1'b0;
            line_age_q   <= '0;
            frame_age_q  <= '0;
        end else begin
            fifo_wr_en_q <= fifo_wr_en_d;
            fifo_din_q   <= fifo_din_d;
            done_q       <= done_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
            last_s1_q    <= last_s1_d;
            line_age_q   <= line_age_d;
            frame_age_q  <= frame_age_d;
        end
    end

    assign fifo_wr_en = fifo_wr_en_q;
    assign fifo_din   = fifo_din_q;
    assign s1_done    = done_q[0];
    assign s2_done    = done_q[1];
    assign line_done  = done_q[2];
    assign frame_done = done_q[3];
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_tdc_fifo_write_arbiter.sv
// tb/tb_tdc_fifo_write_arbiter.sv - directed self-checking bench for tdc_fifo_write_arbiter
module tb_tdc_fifo_write_arbiter;

    localparam logic [63:0] LINE_WORD  = 64'h0001_000D_000D_000D;
    localparam logic [63:0] FRAME_WORD = 64'h0001_000E_000E_000E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s1_req = 1'b0, s2_req = 1'b0, line_req = 1'b0, frame_req = 1'b0;
    logic [47:0] s1_din = '0, s2_din = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [63:0] fifo_din;
    logic        s1_done, s2_done, line_done, frame_done;
    logic [7:0]  drop_count;
    logic        overflow;

    tdc_fifo_write_arbiter #(.MARKER_MAX_WAIT(16), .DROP_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .s1_req(s1_req), .s1_din(s1_din), .s2_req(s2_req), .s2_din(s2_din),
        .line_req(line_req), .frame_req(frame_req), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .s1_done(s1_done), .s2_done(s2_done), .line_done(line_done), .frame_done(frame_done),
        .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] word;
        logic [3:0]  done;
        int          cyc;
    } wr_t;

    wr_t wlog[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_wr_en === 1'b1) wlog.push_back('{fifo_din, {frame_done, line_done, s2_done, s1_done}, cyc});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        s1_req = 0; s2_req = 0; line_req = 0; frame_req = 0; fifo_full = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        wlog.delete();
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #2;
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en got %b want 0", fifo_wr_en); end
        n_cmp++; if (fifo_din !== 64'h0) begin n_bad++; $display("FAIL reset_din got %h want 0", fifo_din); end
        n_cmp++; if ({frame_done, line_done, s2_done, s1_done} !== 4'b0) begin n_bad++; $display("FAIL reset_done got %b want 0000", {frame_done, line_done, s2_done, s1_done}); end
        n_cmp++; if (drop_count !== 8'h0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", drop_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        s1_din = 48'h1234_5678_9ABC; s1_req = 1;
        tick();
        s1_req = 0;
        n_cmp++; if (fifo_wr_en !== 1'b0) begin n_bad++; $display("FAIL single_cycle1_wr_en got %b want 0", fifo_wr_en); end
        tick();
        n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL single_wr_en got %b want 1", fifo_wr_en); end
        n_cmp++; if (fifo_din !== 64'h0001_1234_5678_9ABC) begin n_bad++; $display("FAIL single_din got %h want 0001123456789abc", fifo_din); end
        n_cmp++; if ({frame_done, line_done, s2_done, s1_done} !== 4'b0001) begin n_bad++; $display("FAIL single_done got %b want 0001", {frame_done, line_done, s2_done, s1_done}); end
        tick();
        n_cmp++; if (fifo_wr_en !== 1'b0 || fifo_din !== 64'h0001_1234_5678_9ABC) begin n_bad++; $display("FAIL single_hold got wr_en=%b din=%h want 0/0001123456789abc", fifo_wr_en, fifo_din); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            s1_req = 1; s1_din = 48'h1000 + 48'(i);
            s2_req = 1; s2_din = 48'h2000 + 48'(i);
            tick();
            s1_req = 0; s2_req = 0;
            tick();
        end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (wlog.size() != 20) begin n_bad++; $display("FAIL rr_count got %0d want 20", wlog.size()); end
        for (int i = 0; i < 20 && i < wlog.size(); i++) begin
            logic [63:0] exp_w;
            logic [3:0]  exp_d;
            exp_w = (i % 2 == 0) ? {16'h0001, 48'h1000 + 48'(i/2)} : {16'h0002, 48'h2000 + 48'(i/2)};
            exp_d = (i % 2 == 0) ? 4'b0001 : 4'b0010;
            n_cmp++; if (wlog[i].word !== exp_w || wlog[i].done !== exp_d) begin n_bad++; $display("FAIL rr_write%0d got %h/%b want %h/%b", i, wlog[i].word, wlog[i].done, exp_w, exp_d); end
        end
        n_cmp++; if (drop_count !== 8'h0) begin n_bad++; $display("FAIL rr_drop got %0d want 0", drop_count); end
    endtask

    task automatic test_marker_age();
        int lc;
        int n_line;
        int n_data;
        int line_cyc;
        bit resumed;
        apply_reset();
        s1_din = 48'hAAAA; s2_din = 48'hBBBB;
        s1_req = 1; s2_req = 1;
        for (int i = 0; i < 4; i++) tick();
        line_req = 1; lc = cyc;
        tick();
        line_req = 0;
        for (int i = 0; i < 22; i++) tick();
        s1_req = 0; s2_req = 0;
        for (int i = 0; i < 4; i++) tick();
        n_line = 0; n_data = 0; line_cyc = -1; resumed = 0;
        foreach (wlog[i]) begin
            if (wlog[i].word === LINE_WORD && wlog[i].done === 4'b0100) begin n_line++; line_cyc = wlog[i].cyc; end
            else if (wlog[i].cyc >= lc + 2 && wlog[i].cyc <= lc + 17 && (wlog[i].done === 4'b0001 || wlog[i].done === 4'b0010)) n_data++;
            if (wlog[i].cyc == lc + 19 && (wlog[i].done === 4'b0001 || wlog[i].done === 4'b0010)) resumed = 1;
        end
        n_cmp++; if (n_line != 1) begin n_bad++; $display("FAIL age_line_count got %0d want 1", n_line); end
        n_cmp++; if (line_cyc != lc + 18) begin n_bad++; $display("FAIL age_line_cycle got %0d want %0d", line_cyc, lc + 18); end
        n_cmp++; if (n_data != 16) begin n_bad++; $display("FAIL age_data_before got %0d want 16", n_data); end
        n_cmp++; if (!resumed) begin n_bad++; $display("FAIL age_resume got 0 want 1"); end
    endtask

    task automatic test_full_hold();
        apply_reset();
        fifo_full = 1;
        s1_req = 1; s1_din = 48'hAAAA_BBBB_CCCC; line_req = 1; frame_req = 1;
        tick();
        s1_req = 0; line_req = 0; frame_req = 0;
        for (int i = 0; i < 5; i++) tick();
        s1_req = 1; s1_din = 48'h1111_2222_3333;
        tick();
        s1_req = 0;
        for (int i = 0; i < 13; i++) tick();
        n_cmp++; if (wlog.size() != 0) begin n_bad++; $display("FAIL full_no_write got %0d want 0", wlog.size()); end
        n_cmp++; if (drop_count !== 8'd1) begin n_bad++; $display("FAIL full_drop got %0d want 1", drop_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL full_overflow got %b want 1", overflow); end
        fifo_full = 0;
        for (int i = 0; i < 6; i++) tick();
        n_cmp++; if (wlog.size() != 3) begin n_bad++; $display("FAIL full_release_count got %0d want 3", wlog.size()); end
        if (wlog.size() == 3) begin
            n_cmp++; if (wlog[0].word !== 64'h0001_AAAA_BBBB_CCCC || wlog[0].done !== 4'b0001) begin n_bad++; $display("FAIL full_first got %h/%b want 0001aaaabbbbcccc/0001", wlog[0].word, wlog[0].done); end
            n_cmp++; if (wlog[1].word !== LINE_WORD || wlog[1].done !== 4'b0100) begin n_bad++; $display("FAIL full_second got %h/%b want %h/0100", wlog[1].word, wlog[1].done, LINE_WORD); end
            n_cmp++; if (wlog[2].word !== FRAME_WORD || wlog[2].done !== 4'b1000) begin n_bad++; $display("FAIL full_third got %h/%b want %h/1000", wlog[2].word, wlog[2].done, FRAME_WORD); end
            n_cmp++; if (wlog[2].cyc != wlog[0].cyc + 2) begin n_bad++; $display("FAIL full_back_to_back got %0d want %0d", wlog[2].cyc, wlog[0].cyc + 2); end
        end
    endtask

    task automatic test_same_cycle_reload();
        apply_reset();
        s2_req = 1; s2_din = 48'h0000_0000_5A5A;
        tick();
        s2_din = 48'h0000_0000_A5A5;
        tick();
        s2_req = 0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (wlog.size() != 2) begin n_bad++; $display("FAIL reload_count got %0d want 2", wlog.size()); end
        if (wlog.size() == 2) begin
            n_cmp++; if (wlog[0].word !== 64'h0002_0000_0000_5A5A || wlog[0].done !== 4'b0010) begin n_bad++; $display("FAIL reload_first got %h/%b want 0002000000005a5a/0010", wlog[0].word, wlog[0].done); end
            n_cmp++; if (wlog[1].word !== 64'h0002_0000_0000_A5A5 || wlog[1].cyc != wlog[0].cyc + 1) begin n_bad++; $display("FAIL reload_second got %h@%0d want 000200000000a5a5@%0d", wlog[1].word, wlog[1].cyc, wlog[0].cyc + 1); end
        end
        n_cmp++; if (drop_count !== 8'd0 || overflow !== 1'b0) begin n_bad++; $display("FAIL reload_drop got %0d/%b want 0/0", drop_count, overflow); end
    endtask

    task automatic test_reset_mid();
        wlog.delete();
        s1_req = 1; s1_din = 48'h77; s2_req = 1; s2_din = 48'h88; line_req = 1;
        tick();
        s1_req = 0; s2_req = 0; line_req = 0;
        tick();
        n_cmp++; if (fifo_wr_en !== 1'b1) begin n_bad++; $display("FAIL midrst_pre_write got %b want 1", fifo_wr_en); end
        #2 rst_n = 0;
        #1;
        n_cmp++; if (fifo_wr_en !== 1'b0 || fifo_din !== 64'h0) begin n_bad++; $display("FAIL midrst_outputs got %b/%h want 0/0", fifo_wr_en, fifo_din); end
        n_cmp++; if ({frame_done, line_done, s2_done, s1_done} !== 4'b0 || drop_count !== 8'h0 || overflow !== 1'b0) begin n_bad++; $display("FAIL midrst_status got %b/%0d/%b want 0000/0/0", {frame_done, line_done, s2_done, s1_done}, drop_count, overflow); end
        tick(); tick();
        rst_n = 1;
        wlog.delete();
        for (int i = 0; i < 10; i++) tick();
        n_cmp++; if (wlog.size() != 0) begin n_bad++; $display("FAIL midrst_no_write got %0d want 0", wlog.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_marker_age();
        test_same_cycle_reload();
        test_full_hold();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
